final_color_mixer: RTL

- Final pixel-colour stage between the sprite/layer generators and the VGA output pins.
- Composites N_LAYERS colour layers by fixed priority, with transparency and a background colour.
- Forces a blanking colour outside the visible window and applies a frame-timed "flash" inversion effect (hit/game-over feedback).
- Fully registered, two-stage pipeline, advanced by the pixel clock enable.

---
 rtl/final_color_mixer_if.sv | 23 ++
 rtl/final_color_mixer.sv | 106 ++++++++++
 2 files changed

// File: rtl/final_color_mixer_if.sv
// rtl/final_color_mixer_if.sv - pixel bus between layer generators and the final colour mixer
// master drives position/layers/enable, slave returns the composited colour.
interface final_color_mixer_if #(
  parameter int N_LAYERS = 4,
  parameter int COLOR_W  = 3
);
  logic                        ce;
  logic [9:0]                  hPos;
  logic [9:0]                  vPos;
  logic [N_LAYERS*COLOR_W-1:0] layer_color;
  logic [COLOR_W-1:0]          color;
  logic                        visible;

  modport master (
    output ce, hPos, vPos, layer_color,
    input  color, visible
  );

  modport slave (
    input  ce, hPos, vPos, layer_color,
    output color, visible
  );
endinterface

// File: rtl/final_color_mixer.sv
// rtl/final_color_mixer.sv - two-stage priority compositor with blanking and frame-timed flash inversion
// Optional border overlay when FINAL_COLOR_BORDER_EN is defined.
module final_color_mixer #(
  parameter int N_LAYERS     = 4,
  parameter int COLOR_W      = 3,
  parameter int H_VISIBLE    = 640,
  parameter int V_VISIBLE    = 480,
  parameter int TRANSPARENT  = 7,
  parameter int BG_COLOR     = 0,
  parameter int BLANK_COLOR  = 7,
`ifdef FINAL_COLOR_BORDER_EN
  parameter int BORDER_W     = 2,
  parameter int BORDER_COLOR = 4,
`endif
  parameter int FLASH_FRAMES = 32,
  parameter int FLASH_PERIOD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  final_color_mixer_if.slave pix,
  input  logic               flash_req,
  output logic               flash_busy
);

  localparam logic [COLOR_W-1:0] TRANSP_C   = COLOR_W'(TRANSPARENT);
  localparam logic [COLOR_W-1:0] BG_C       = COLOR_W'(BG_COLOR);
  localparam logic [COLOR_W-1:0] BLANK_C    = COLOR_W'(BLANK_COLOR);
  localparam logic [9:0]         H_VIS_C    = 10'(H_VISIBLE);
  localparam logic [9:0]         V_VIS_C    = 10'(V_VISIBLE);
  localparam logic [7:0]         FRAMES_C   = 8'(FLASH_FRAMES);
  localparam logic [7:0]         PERIOD_C   = 8'(FLASH_PERIOD);
  localparam logic [7:0]         PHASE_MASK = 8'(FLASH_PERIOD * 2 - 1);
`ifdef FINAL_COLOR_BORDER_EN
  localparam logic [COLOR_W-1:0] BORDER_C   = COLOR_W'(BORDER_COLOR);
  localparam logic [9:0]         BW_C       = 10'(BORDER_W);
  localparam logic [9:0]         H_BEND_C   = 10'(H_VISIBLE - BORDER_W);
  localparam logic [9:0]         V_BEND_C   = 10'(V_VISIBLE - BORDER_W);
`endif

  typedef enum logic {IDLE, FLASH} flashStateT;

  flashStateT         state;
  logic [7:0]         frameCnt;
  logic [7:0]         phaseCnt;
  logic               visNext;
  logic [COLOR_W-1:0] selNext;
  logic               visS1;
  logic [COLOR_W-1:0] selS1;
  logic               frameStart;
  logic               invertActive;

  assign visNext      = (pix.hPos < H_VIS_C) && (pix.vPos < V_VIS_C);
  assign frameStart   = pix.ce && (pix.hPos == 10'd0) && (pix.vPos == 10'd0);
  assign invertActive = (state == FLASH) && (phaseCnt < PERIOD_C);

  // Walk from the lowest priority upward so the lowest opaque index is the one left standing.
  always_comb begin
    selNext = BG_C;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (pix.layer_color[i*COLOR_W +: COLOR_W] != TRANSP_C)
        selNext = pix.layer_color[i*COLOR_W +: COLOR_W];
    end
`ifdef FINAL_COLOR_BORDER_EN
    if (visNext && (pix.hPos < BW_C || pix.hPos >= H_BEND_C ||
                    pix.vPos < BW_C || pix.vPos >= V_BEND_C))
      selNext = BORDER_C;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      visS1       <= 1'b0;
      selS1       <= '0;
      pix.visible <= 1'b0;
      pix.color   <= BLANK_C;
    end else if (pix.ce) begin
      visS1       <= visNext;
      selS1       <= selNext;
      pix.visible <= visS1;
      pix.color   <= visS1 ? (invertActive ? ~selS1 : selS1) : BLANK_C;
    end
  end

  // A request always wins, including over the frame start that would end the flash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frameCnt   <= 8'd0;
      phaseCnt   <= 8'd0;
      flash_busy <= 1'b0;
    end else if (flash_req) begin
      state      <= FLASH;
      frameCnt   <= FRAMES_C;
      phaseCnt   <= 8'd0;
      flash_busy <= 1'b1;
    end else if (state == FLASH && frameStart) begin
      frameCnt <= frameCnt - 8'd1;
      phaseCnt <= (phaseCnt + 8'd1) & PHASE_MASK;
      if (frameCnt == 8'd1) begin
        state      <= IDLE;
        flash_busy <= 1'b0;
      end
    end
  end

endmodule
